muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//   Iterative RV32M multiply/divide engine and its sequencing FSM, sitting beside the main ALU in EX.
//   Latches operands on start and runs a radix-2 shift-add multiply or restoring divide, one bit per cycle.
//   Pulses ready for one cycle; ready drives CONTROL_UNIT.MulDivAluReady, gating RegWrite and Stall.
// PARAMETERS
//   BITS   32   operand/result width; iteration count; must be >= 4
// PORTS
//   clk     in   1     clock, rising edge
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     M-ext instruction in EX (Opcode==R_Type && Funct7==7'b000_0001); level, held while stalled
//   kill    in   1     synchronous abort (pipeline flush); priority over start
//   funct3  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   rs1     in   BITS  operand A (dividend / multiplicand)
//   rs2     in   BITS  operand B (divisor / multiplier)
//   result  out  BITS  registered result; valid only while ready==1
//   ready   out  1     one-cycle pulse, result valid (-> MulDivAluReady)
//   busy    out  1     high in BUSY or DONE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, count=0, result=0, ready=0, busy=0, all internal regs 0.
//   States: IDLE -> BUSY -> DONE -> IDLE; IDLE -> DONE for special-case ops.
//   IDLE: start&~kill at edge t0 -> latch funct3, |rs1|, |rs2|, sign flags; count=0; go BUSY.
//     Signed magnitude: MULH/DIV/REM both operands signed; MULHSU rs1 signed, rs2 unsigned; others unsigned.
//     abs(-2^(BITS-1)) = 2^(BITS-1) as unsigned; no overflow.
//   Special cases at t0 go straight to DONE (ready in cycle t0+1):
//     div-by-zero (rs2==0): DIV/DIVU q = all ones; REM/REMU r = rs1.
//     signed overflow (rs1==-2^(BITS-1), rs2==-1): DIV q = rs1; REM r = 0.
//   BUSY: one iteration per cycle, count 0..BITS-1; after count==BITS-1 go DONE.
//     MUL*: 2*BITS-bit product accumulator, shift-add on multiplier LSB.
//     DIV*/REM*: restoring; partial remainder BITS+1 bits; quotient shifted in LSB-first from MSB.
//   DONE: ready=1, result registered on the BUSY->DONE edge; next edge -> IDLE unconditionally.
//     Normal-op latency: start sampled at t0, ready high during cycle t0+BITS+1 (33 for BITS=32).
//   Final sign fix-up applied before result register:
//     product negated if signA^signB; quotient negated if signA^signB; remainder takes sign of dividend.
//     MUL returns low BITS of product; MULH/MULHSU/MULHU return high BITS.
//   start ignored in BUSY/DONE. Operand inputs may change after t0 without effect.
//   Back-to-back: start still high in the IDLE cycle after DONE starts a new op (pipeline has advanced).
//   kill in BUSY or DONE: -> IDLE next edge, ready forced 0, result unchanged; kill&start in IDLE: stay IDLE.
//   busy=1 in BUSY/DONE. ready and busy are registered (decoded from state register), glitch-free.
//   No output X after reset regardless of input X on rs1/rs2 when start=0.
// TESTING
//   MUL rs1=7, rs2=0xFFFFFFFD -> ready only in cycle t0+33, result=0xFFFFFFEB; ready low all other cycles.
//   MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE.
//   DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//   DIVU x/0 -> 0xFFFFFFFF and REM 0x1234/0 -> 0x1234, both ready at t0+1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//   kill at count=10 -> IDLE next cycle, no ready pulse; rst_n low at count=20 -> immediate IDLE, ready=0, result=0.
//   start held high across two ops (MUL then DIVU) -> two ready pulses at t0+33 and t0+67, correct results, no missed op.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Purpose: iterative RV32M multiply/divide engine (radix-2 shift-add / restoring divide) with its sequencing FSM.
// Latency: ready pulses in the 33rd cycle after start is sampled (BITS+1), or in the 1st cycle for div-by-zero/overflow.
// Backpressure: none; start is a level held by the stalled pipeline, ignored while busy; kill aborts without a ready pulse.
module muldiv_sequencer #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [BITS-1:0] rs1,
  input  logic [BITS-1:0] rs2,
  output logic [BITS-1:0] result,
  output logic            ready,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0]   LAST    = CW'(BITS - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [BITS-1:0] MIN_VAL = {1'b1, {(BITS-1){1'b0}}};

  state_t state, state_nxt;

  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic              sign_a, sign_b;
  logic [BITS-1:0]   opnd;      // multiplicand (MUL*) or divisor (DIV*/REM*) magnitude
  logic [2*BITS-1:0] acc;       // product accumulator, or quotient/dividend shifter in the low half
  logic [BITS:0]     rem;       // partial remainder

  // Operand decode at the start edge
  logic            is_div_in, a_signed_in, b_signed_in, sa_in, sb_in;
  logic [BITS-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf, special_in;
  logic [BITS-1:0] special_res;

  assign is_div_in   = funct3[2];
  assign a_signed_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sa_in       = a_signed_in & rs1[BITS-1];
  assign sb_in       = b_signed_in & rs2[BITS-1];
  // Negating -2^(BITS-1) yields the same bit pattern, which is the correct unsigned magnitude.
  assign abs_a       = sa_in ? -rs1 : rs1;
  assign abs_b       = sb_in ? -rs2 : rs2;

  assign div_zero    = is_div_in && (rs2 == '0);
  assign div_ovf     = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                       (rs1 == MIN_VAL) && (rs2 == '1);
  assign special_in  = div_zero || div_ovf;
  // funct3[1] selects the remainder flavours
  assign special_res = funct3[1] ? (div_zero ? rs1 : '0) : (div_zero ? '1 : rs1);

  // One iteration of each algorithm
  logic [BITS:0]     mul_sum;
  logic [2*BITS-1:0] mul_next;
  logic [BITS+1:0]   div_shift, div_diff;
  logic              div_ge;
  logic [BITS:0]     div_rem_next;
  logic [BITS-1:0]   div_q_next;

  assign mul_sum      = {1'b0, acc[2*BITS-1:BITS]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next     = {mul_sum, acc[BITS-1:1]};
  assign div_shift    = {rem, acc[BITS-1]};
  assign div_diff     = div_shift - {2'b00, opnd};
  assign div_ge       = ~div_diff[BITS+1];
  assign div_rem_next = div_ge ? div_diff[BITS:0] : div_shift[BITS:0];
  assign div_q_next   = {acc[BITS-2:0], div_ge};

  // Sign fix-up on the final iteration's values
  logic [2*BITS-1:0] prod;
  logic [BITS-1:0]   quot, remf, final_res;

  assign prod = (sign_a ^ sign_b) ? -mul_next : mul_next;
  assign quot = (sign_a ^ sign_b) ? -div_q_next : div_q_next;
  assign remf = sign_a ? -div_rem_next[BITS-1:0] : div_rem_next[BITS-1:0];

  // Result select by the latched opcode
  always_comb begin
    final_res = '0;
    case (op)
      3'b000:                 final_res = prod[BITS-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*BITS-1:BITS];
      3'b100, 3'b101:         final_res = quot;
      default:                final_res = remf;
    endcase
  end

  // Next-state logic: kill wins over start, DONE always lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !kill) state_nxt = special_in ? DONE : BUSY;
      BUSY: begin
        if (kill)                state_nxt = IDLE;
        else if (count == LAST)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; ready/busy are registered decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == DONE);
      busy  <= (state_nxt != IDLE);
    end
  end

  // Datapath: latch operands on start, iterate while BUSY, capture the result on the way into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      rem    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !kill) begin
            op     <= funct3;
            sign_a <= sa_in;
            sign_b <= sb_in;
            count  <= '0;
            rem    <= '0;
            opnd   <= is_div_in ? abs_b : abs_a;
            acc    <= {{BITS{1'b0}}, (is_div_in ? abs_a : abs_b)};
            if (special_in) result <= special_res;
          end
        end
        BUSY: begin
          if (!kill) begin
            count <= count + CNT_ONE;
            if (op[2]) begin
              acc <= {{BITS{1'b0}}, div_q_next};
              rem <= div_rem_next;
            end else begin
              acc <= mul_next;
            end
            if (count == LAST) result <= final_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
